// File: rtl/operand_stack.sv
// Operand stack feeding the ALU: exposes the top two entries, accepts ALU writeback,
// and keeps sticky overflow/underflow flags. Outputs depend only on registered state.
module operand_stack #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       cmd,
   input  logic [WIDTH-1:0] push_data,
   input  logic [WIDTH-1:0] wb0,
   input  logic [WIDTH-1:0] wb1,
   input  logic             err_clr,
   output logic [WIDTH-1:0] stack0,
   output logic [WIDTH-1:0] stack1,
   output logic [CW-1:0]    depth,
   output logic             empty,
   output logic             full,
   output logic             err_ovf,
   output logic             err_unf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      CMD_NOP      = 3'b000,
      CMD_PUSH     = 3'b001,
      CMD_POP      = 3'b010,
      CMD_REDUCE   = 3'b011,
      CMD_REPLACE2 = 3'b100,
      CMD_REPLACE1 = 3'b101,
      CMD_DUP      = 3'b110,
      CMD_SWAP     = 3'b111
   } cmd_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CW-1:0]    sp_q, sp_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_unf_q, err_unf_d;
   logic             ovf_set, unf_set;
   logic             has1, has2, is_full;
   logic [AW-1:0]    idx0, idx1, idx_new;

   assign has1    = (sp_q != '0);
   assign has2    = (sp_q >= CW'(2));
   assign is_full = (sp_q == CW'(DEPTH));

   // Slot indices are only used when the guarding depth checks pass, so truncation is safe.
   assign idx0    = AW'(sp_q - CW'(1));
   assign idx1    = AW'(sp_q - CW'(2));
   assign idx_new = AW'(sp_q);

   always_comb begin
      mem_d   = mem_q;
      sp_d    = sp_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      case (cmd_e'(cmd))
         CMD_NOP: ;
         CMD_PUSH: begin
            if (is_full) begin
               ovf_set = 1'b1;
            end else begin
               mem_d[idx_new] = push_data;
               sp_d           = sp_q + CW'(1);
            end
         end
         CMD_POP: begin
            if (!has1) unf_set = 1'b1;
            else       sp_d    = sp_q - CW'(1);
         end
         CMD_REDUCE: begin
            if (!has2) begin
               unf_set = 1'b1;
            end else begin
               mem_d[idx1] = wb0;
               sp_d        = sp_q - CW'(1);
            end
         end
         CMD_REPLACE2: begin
            if (!has2) begin
               unf_set = 1'b1;
            end else begin
               mem_d[idx0] = wb0;
               mem_d[idx1] = wb1;
            end
         end
         CMD_REPLACE1: begin
            if (!has1) unf_set     = 1'b1;
            else       mem_d[idx0] = wb0;
         end
         CMD_DUP: begin
            if (!has1) begin
               unf_set = 1'b1;
            end else if (is_full) begin
               ovf_set = 1'b1;
            end else begin
               mem_d[idx_new] = mem_q[idx0];
               sp_d           = sp_q + CW'(1);
            end
         end
         CMD_SWAP: begin
            if (!has2) begin
               unf_set = 1'b1;
            end else begin
               mem_d[idx0] = mem_q[idx1];
               mem_d[idx1] = mem_q[idx0];
            end
         end
         default: ;
      endcase
      // A fresh error wins over a simultaneous clear of its own flag.
      err_ovf_d = (err_ovf_q & ~err_clr) | ovf_set;
      err_unf_d = (err_unf_q & ~err_clr) | unf_set;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp_q      <= '0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         sp_q      <= sp_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) mem_q <= mem_d;
   end

   assign stack0  = has1 ? mem_q[idx0] : '0;
   assign stack1  = has2 ? mem_q[idx1] : '0;
   assign depth   = sp_q;
   assign empty   = !has1;
   assign full    = is_full;
   assign err_ovf = err_ovf_q;
   assign err_unf = err_unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack with hand-computed expectations.
module tb_operand_stack;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, REDUCE = 3'b011;
   localparam logic [2:0] REP2 = 3'b100, REP1 = 3'b101, DUP = 3'b110, SWAP = 3'b111;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       cmd;
   logic [WIDTH-1:0] push_data, wb0, wb1;
   logic             err_clr;
   logic [WIDTH-1:0] stack0, stack1;
   logic [CW-1:0]    depth;
   logic             empty, full, err_ovf, err_unf;

   int n_cmp = 0;
   int n_err = 0;

   operand_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .push_data(push_data),
      .wb0(wb0), .wb1(wb1), .err_clr(err_clr),
      .stack0(stack0), .stack1(stack1), .depth(depth),
      .empty(empty), .full(full), .err_ovf(err_ovf), .err_unf(err_unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [2:0] c, input logic [7:0] d, input logic [7:0] w0,
                       input logic [7:0] w1, input logic clr, input logic rn);
      @(negedge clk);
      cmd = c; push_data = d; wb0 = w0; wb1 = w1; err_clr = clr; rst_n = rn;
      @(posedge clk);
      #1;
      cmd = NOP; err_clr = 1'b0; rst_n = 1'b1;
   endtask

   task automatic op(input logic [2:0] c, input logic [7:0] d);
      step(c, d, 8'd0, 8'd0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      step(NOP, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic chk_state(input string tag, input int s0, input int s1, input int d,
                            input int ovf, input int unf);
      check({tag, ".stack0"}, int'(stack0), s0);
      check({tag, ".stack1"}, int'(stack1), s1);
      check({tag, ".depth"},  int'(depth),  d);
      check({tag, ".ovf"},    int'(err_ovf), ovf);
      check({tag, ".unf"},    int'(err_unf), unf);
   endtask

   initial begin
      rst_n = 1'b0; cmd = NOP; push_data = '0; wb0 = '0; wb1 = '0; err_clr = 1'b0;
      do_reset();
      do_reset();
      chk_state("reset", 0, 0, 0, 0, 0);
      check("reset.empty", int'(empty), 1);
      check("reset.full",  int'(full),  0);

      op(PUSH, 8'd34);
      op(PUSH, 8'd76);
      chk_state("push2", 76, 34, 2, 0, 0);
      step(REDUCE, 8'd0, 8'd110, 8'd0, 1'b0, 1'b1);
      chk_state("reduce", 110, 0, 1, 0, 0);

      op(PUSH, 8'd50);
      op(PUSH, 8'd30);
      op(SWAP, 8'd0);
      chk_state("swap", 50, 30, 3, 0, 0);
      step(REP2, 8'd0, 8'hAA, 8'h0A, 1'b0, 1'b1);
      chk_state("replace2", 8'hAA, 8'h0A, 3, 0, 0);

      do_reset();
      for (int i = 1; i <= 8; i++) op(PUSH, 8'(i));
      chk_state("fill", 8, 7, 8, 0, 0);
      check("fill.full", int'(full), 1);
      op(PUSH, 8'd9);
      chk_state("push_full", 8, 7, 8, 1, 0);
      op(DUP, 8'd0);
      chk_state("dup_full", 8, 7, 8, 1, 0);

      for (int i = 0; i < 7; i++) op(POP, 8'd0);
      chk_state("pop_to_1", 1, 0, 1, 1, 0);
      op(POP, 8'd0);
      check("pop_to_0.empty", int'(empty), 1);
      op(POP, 8'd0);
      chk_state("pop_empty", 0, 0, 0, 1, 1);
      step(REDUCE, 8'd0, 8'd99, 8'd0, 1'b1, 1'b1);
      chk_state("clr_with_err", 0, 0, 0, 0, 1);
      step(NOP, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
      chk_state("clr_nop", 0, 0, 0, 0, 0);

      step(REP1, 8'd0, 8'd42, 8'd0, 1'b0, 1'b1);
      chk_state("rep1_empty", 0, 0, 0, 0, 1);
      step(NOP, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
      op(PUSH, 8'hFB);
      chk_state("push_fb", 8'hFB, 0, 1, 0, 0);
      step(REP1, 8'd0, 8'd5, 8'd0, 1'b0, 1'b1);
      chk_state("replace1", 5, 0, 1, 0, 0);
      op(DUP, 8'd0);
      chk_state("dup", 5, 5, 2, 0, 0);
      op(SWAP, 8'd0);
      op(POP, 8'd0);
      chk_state("pop_stale", 5, 0, 1, 0, 0);
      op(SWAP, 8'd0);
      chk_state("swap_short", 5, 0, 1, 0, 1);

      do_reset();
      op(PUSH, 8'd11);
      op(PUSH, 8'd22);
      op(PUSH, 8'd33);
      chk_state("push3", 33, 22, 3, 0, 0);
      step(PUSH, 8'd44, 8'd0, 8'd0, 1'b0, 1'b0);
      chk_state("reset_mid", 0, 0, 0, 0, 0);
      check("reset_mid.empty", int'(empty), 1);
      op(PUSH, 8'd7);
      chk_state("post_reset_push", 7, 0, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Hardware operand stack directly upstream of the ALU. It supplies the top two entries as the ALU's stack0/stack1 operands.
- It consumes the ALU's stack0_out/stack1_out results on writeback commands issued by the decoder.
- It tracks depth and flags overflow/underflow with sticky error bits.

Parameters:
- DEPTH, 8, number of stack entries (legal values: 2 or more).
- WIDTH, 8, entry width in bits.
- CW, $clog2(DEPTH+1), width of the depth count (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- cmd  in  3  stack command, sampled every rising edge (encoding below).
- push_data  in  WIDTH  value pushed by PUSH.
- wb0  in  WIDTH  ALU result for the top slot (from ALU stack0_out).
- wb1  in  WIDTH  ALU result for the second slot (from ALU stack1_out).
- err_clr  in  1  clears the sticky error flags.
- stack0  out  WIDTH  top entry (mem[sp-1]); 0 when sp<1.
- stack1  out  WIDTH  second entry (mem[sp-2]); 0 when sp<2.
- depth  out  CW  current entry count sp.
- empty  out  1  sp==0.
- full  out  1  sp==DEPTH.
- err_ovf  out  1  sticky overflow flag.
- err_unf  out  1  sticky underflow flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - rst_n low at an edge sets sp=0, err_ovf=0, err_unf=0. Memory contents are don't-care.
  - After reset: stack0=0, stack1=0, depth=0, empty=1, full=0.
  - rst_n overrides cmd and err_clr, including mid-sequence.
- Timing: every output is a combinational function of registered state only. A command sampled at edge N is visible on the outputs after edge N. There is no handshake; one command is accepted per cycle.
- Commands (effect at the edge):
  - 000 NOP: no change.
  - 001 PUSH: mem[sp]=push_data; sp+1. If full: no change, set err_ovf.
  - 010 POP: sp-1. If empty: no change, set err_unf.
  - 011 REDUCE (binary ALU op, 2 operands in, 1 result out): mem[sp-2]=wb0; sp-1. If sp<2: no change, set err_unf.
  - 100 REPLACE2: mem[sp-1]=wb0; mem[sp-2]=wb1; sp unchanged. If sp<2: no change, set err_unf.
  - 101 REPLACE1 (unary op, e.g. abs/inc): mem[sp-1]=wb0. If empty: no change, set err_unf.
  - 110 DUP: mem[sp]=mem[sp-1]; sp+1. If empty: set err_unf. Else if full: set err_ovf. Any failure leaves the state unchanged.
  - 111 SWAP: exchange mem[sp-1] and mem[sp-2]. If sp<2: no change, set err_unf.
- Illegal commands never modify sp or memory.
- Sticky flags:
  - Set on a failing command; held until reset or err_clr.
  - err_clr together with a new error in the same cycle: the new error's flag ends at 1; the other flag clears.
- Arithmetic: sp never wraps. It is bounded to 0..DEPTH. Data is stored verbatim; the stack performs no arithmetic.
- Writes to slots at or above sp are invisible. A stale slot must never appear on stack0/stack1; those outputs read 0 for absent entries.

Test Plan:
- Reset, then PUSH 34, PUSH 76 -> stack0=76, stack1=34, depth=2. REDUCE with wb0=110 -> stack0=110, stack1=0, depth=1, no errors.
- PUSH 50, PUSH 30, SWAP -> stack0=50, stack1=30. REPLACE2 with wb0=8'hAA, wb1=8'h0A -> stack0=8'hAA, stack1=8'h0A, depth unchanged.
- PUSH 1..8 (DEPTH=8) -> full=1, stack0=8. PUSH 9 -> err_ovf=1, depth=8, stack0=8. DUP -> still 8 entries, stack0=8.
- From empty: POP -> err_unf=1, depth=0. Then err_clr with REDUCE in the same cycle -> err_unf stays 1. Next err_clr with NOP -> both flags 0.
- PUSH 8'hFB, REPLACE1 with wb0=5 -> stack0=5, depth=1. DUP -> stack0=5, stack1=5, depth=2.
- Push 3 entries, assert rst_n=0 together with cmd=PUSH -> depth=0, stack0=0, empty=1. PUSH 7 after release -> stack0=7, stack1=0.
